// File: rtl/lieat_bitcnt_pkg.sv
// rtl/lieat_bitcnt_pkg.sv - shared op encodings and sizing helper for the bit-scan unit
// Contents:
//   bitcnt_op_t  2-bit operation code
//   BITCNT_*     operation encodings (CLZ, CTZ, CPOP, reserved)
//   cnt_width    width of a count able to hold 0..width inclusive
package lieat_bitcnt_pkg;

    typedef logic [1:0] bitcnt_op_t;

    localparam bitcnt_op_t BITCNT_CLZ  = 2'd0;
    localparam bitcnt_op_t BITCNT_CTZ  = 2'd1;
    localparam bitcnt_op_t BITCNT_CPOP = 2'd2;
    localparam bitcnt_op_t BITCNT_RSV  = 2'd3;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/lieat_bitcnt_pipe_lzc_chunk.sv
// rtl/lieat_bitcnt_pipe_lzc_chunk.sv - combinational per-slice zero flag, leading-zero count and popcount
// Module lieat_lzc_chunk
// Ports:
//   data_i  in   CHUNK-bit slice
//   zero_o  out  slice is all-zero
//   lzc_o   out  leading zeros from the slice MSB (CHUNK when all-zero)
//   pop_o   out  number of set bits in the slice
module lieat_lzc_chunk
    import lieat_bitcnt_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]         data_i,
    output logic                     zero_o,
    output logic [$clog2(CHUNK):0]   lzc_o,
    output logic [$clog2(CHUNK):0]   pop_o
);

    localparam int LW = cnt_width(CHUNK);

    always_comb begin
        lzc_o = LW'(CHUNK);
        pop_o = '0;
        // Ascending scan: the highest set bit is the last one to write lzc_o.
        for (int i = 0; i < CHUNK; i++) begin
            if (data_i[i]) begin
                lzc_o = LW'(CHUNK - 1 - i);
            end
            pop_o = pop_o + LW'(data_i[i]);
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/lieat_bitcnt_pipe.sv
// rtl/lieat_bitcnt_pipe.sv - two-stage pipelined CLZ/CTZ/CPOP unit with valid/ready, tag and flush
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush_i                    kill all in-flight operations
//   in_valid_i/in_ready_o      input handshake
//   in_data_i, in_op_i         operand and operation (0 CLZ, 1 CTZ, 2 CPOP, 3 reserved)
//   in_word_i                  operate on the low 32 bits (WIDTH=64 only)
//   in_tag_i                   opaque tag carried to the output
//   out_valid_o/out_ready_i    output handshake
//   out_cnt_o, out_zero_o      result count and effective-operand-zero flag
//   out_tag_o                  tag of the result
module lieat_bitcnt_pipe
    import lieat_bitcnt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [WIDTH-1:0]        in_data_i,
    input  logic [1:0]              in_op_i,
    input  logic                    in_word_i,
    input  logic [TAG_W-1:0]        in_tag_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [$clog2(WIDTH):0]  out_cnt_o,
    output logic                    out_zero_o,
    output logic [TAG_W-1:0]        out_tag_o
);

    localparam int CW  = cnt_width(WIDTH);
    localparam int LW  = cnt_width(CHUNK);
    localparam int NCH = WIDTH / CHUNK;

    // Operand conditioning: CTZ is a CLZ of the bit-reversed operand, and the
    // effective operand is MSB-aligned so the slice scan always starts at the top.
    logic             is_ctz;
    logic             word_mode;
    logic [WIDTH-1:0] data_rev;
    logic [WIDTH-1:0] scan_data;

    assign is_ctz = (in_op_i == BITCNT_CTZ);

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            data_rev[i] = in_data_i[WIDTH-1-i];
        end
    end

    generate
        if (WIDTH == 64) begin : g_w64
            logic [31:0] lo_rev;
            always_comb begin
                for (int i = 0; i < 32; i++) begin
                    lo_rev[i] = in_data_i[31-i];
                end
            end
            assign word_mode = in_word_i;
            // W-mode places the low word in the top half; the zero padding below
            // adds nothing to popcounts and is never reached by a non-zero scan.
            assign scan_data = in_word_i ? {(is_ctz ? lo_rev : in_data_i[31:0]), 32'b0}
                                         : (is_ctz ? data_rev : in_data_i);
        end else begin : g_w32
            // W-mode is the full operand at 32 bits.
            assign word_mode = in_word_i & 1'b0;
            assign scan_data = is_ctz ? data_rev : in_data_i;
        end
    endgenerate

    logic [NCH-1:0] c_zero;
    logic [LW-1:0]  c_lzc [NCH];
    logic [LW-1:0]  c_pop [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_chunk
        lieat_lzc_chunk #(.CHUNK(CHUNK)) u_chunk (
            .data_i (scan_data[g*CHUNK +: CHUNK]),
            .zero_o (c_zero[g]),
            .lzc_o  (c_lzc[g]),
            .pop_o  (c_pop[g])
        );
    end

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv, in_fire;

    assign s2_adv     = ~s2_valid_q | out_ready_i;
    assign s1_adv     = ~s1_valid_q | s2_adv;
    assign in_ready_o = s1_adv;
    assign in_fire    = in_valid_i & s1_adv & ~flush_i;

    // Stage 1 state
    logic [NCH-1:0]   s1_zero_q, s1_zero_d;
    logic [LW-1:0]    s1_lzc_q [NCH];
    logic [LW-1:0]    s1_lzc_d [NCH];
    logic [LW-1:0]    s1_pop_q [NCH];
    logic [LW-1:0]    s1_pop_d [NCH];
    bitcnt_op_t       s1_op_q, s1_op_d;
    logic             s1_word_q, s1_word_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_zero_d  = s1_zero_q;
        s1_lzc_d   = s1_lzc_q;
        s1_pop_d   = s1_pop_q;
        s1_op_d    = s1_op_q;
        s1_word_d  = s1_word_q;
        s1_tag_d   = s1_tag_q;
        if (s1_adv) begin
            s1_valid_d = in_fire;
        end
        if (in_fire) begin
            s1_zero_d = c_zero;
            s1_lzc_d  = c_lzc;
            s1_pop_d  = c_pop;
            s1_op_d   = in_op_i;
            s1_word_d = word_mode;
            s1_tag_d  = in_tag_i;
        end
        if (flush_i) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 reduction across slices
    logic [CW-1:0] lz_cnt;
    logic [CW-1:0] pop_sum;

    always_comb begin
        lz_cnt  = s1_word_q ? CW'(32) : CW'(WIDTH);
        pop_sum = '0;
        // Ascending scan: the highest non-zero slice is the last one to write lz_cnt.
        for (int i = 0; i < NCH; i++) begin
            pop_sum = pop_sum + CW'(s1_pop_q[i]);
            if (!s1_zero_q[i]) begin
                lz_cnt = CW'((NCH - 1 - i) * CHUNK) + CW'(s1_lzc_q[i]);
            end
        end
    end

    logic [CW-1:0]    s2_cnt_q, s2_cnt_d;
    logic             s2_zero_q, s2_zero_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_cnt_d   = s2_cnt_q;
        s2_zero_d  = s2_zero_q;
        s2_tag_d   = s2_tag_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_zero_d = &s1_zero_q;
                s2_tag_d  = s1_tag_q;
                case (s1_op_q)
                    BITCNT_CLZ, BITCNT_CTZ: s2_cnt_d = lz_cnt;
                    BITCNT_CPOP:            s2_cnt_d = pop_sum;
                    default:                s2_cnt_d = '0;
                endcase
            end
        end
        if (flush_i) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_zero_q  <= '0;
            s1_op_q    <= BITCNT_CLZ;
            s1_word_q  <= 1'b0;
            s1_tag_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                s1_lzc_q[i] <= '0;
                s1_pop_q[i] <= '0;
            end
            s2_valid_q <= 1'b0;
            s2_cnt_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_zero_q  <= s1_zero_d;
            s1_lzc_q   <= s1_lzc_d;
            s1_pop_q   <= s1_pop_d;
            s1_op_q    <= s1_op_d;
            s1_word_q  <= s1_word_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_zero_q  <= s2_zero_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_cnt_o   = s2_cnt_q;
    assign out_zero_o  = s2_zero_q;
    assign out_tag_o   = s2_tag_q;

endmodule

// File: tb/tb_lieat_bitcnt_pipe.sv
// tb/tb_lieat_bitcnt_pipe.sv - self-checking bench for lieat_bitcnt_pipe at WIDTH=64
module tb_lieat_bitcnt_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] in_data_i = '0;
    logic [1:0]  in_op_i = '0;
    logic        in_word_i = 1'b0;
    logic [5:0]  in_tag_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [6:0]  out_cnt_o;
    logic        out_zero_o;
    logic [5:0]  out_tag_o;

    lieat_bitcnt_pipe #(.WIDTH(64), .CHUNK(8), .TAG_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_op_i     (in_op_i),
        .in_word_i   (in_word_i),
        .in_tag_i    (in_tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_cnt_o   (out_cnt_o),
        .out_zero_o  (out_zero_o),
        .out_tag_o   (out_tag_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int flushed_seen = 0;

    typedef struct {
        int       cnt;
        bit       zero;
        bit [5:0] tag;
        int       acc;
    } exp_t;

    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: count directly on the effective operand, bit by bit.
    function automatic int ref_cnt(input logic [63:0] d, input logic [1:0] op, input logic w);
        int ew;
        int r;
        ew = w ? 32 : 64;
        r = 0;
        case (op)
            2'd0: begin
                r = ew;
                for (int i = ew - 1; i >= 0; i--) if (d[i]) begin r = ew - 1 - i; break; end
            end
            2'd1: begin
                r = ew;
                for (int i = 0; i < ew; i++) if (d[i]) begin r = i; break; end
            end
            2'd2: for (int i = 0; i < ew; i++) r += int'(d[i]);
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic bit ref_zero(input logic [63:0] d, input logic w);
        int ew;
        ew = w ? 32 : 64;
        for (int i = 0; i < ew; i++) if (d[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Occupancy model: items in flight in acceptance order; the oldest item is
    // visible two edges after acceptance, and a third item fits only if the
    // output is being drained.
    int   n_q;
    bit   ev;
    bit   er;
    exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            n_q = q.size();
            ev = (n_q > 0) && (cyc - q[0].acc >= 2);
            er = (n_q < 2) || out_ready_i;
            chk("out_valid", {63'b0, out_valid_o}, {63'b0, ev});
            chk("in_ready", {63'b0, in_ready_o}, {63'b0, er});
            if (ev) begin
                chk("out_cnt", {57'b0, out_cnt_o}, 64'(q[0].cnt));
                chk("out_zero", {63'b0, out_zero_o}, {63'b0, q[0].zero});
                chk("out_tag", {58'b0, out_tag_o}, {58'b0, q[0].tag});
            end
            if (out_valid_o && out_ready_i && (out_tag_o == 6'h30 || out_tag_o == 6'h31))
                flushed_seen++;
            if (flush_i) begin
                q.delete();
            end else begin
                if (ev && out_ready_i) void'(q.pop_front());
                if (in_valid_i && er) begin
                    e.cnt  = ref_cnt(in_data_i, in_op_i, in_word_i);
                    e.zero = ref_zero(in_data_i, in_word_i);
                    e.tag  = in_tag_i;
                    e.acc  = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    // Single op into an idle pipe, checked against hand-computed literals.
    task automatic direct(input string name, input logic [63:0] d, input logic [1:0] op,
                          input logic w, input logic [5:0] tag, input int ecnt, input bit ezero);
        @(posedge clk); #1;
        in_valid_i = 1'b1; in_data_i = d; in_op_i = op; in_word_i = w; in_tag_i = tag;
        out_ready_i = 1'b1; flush_i = 1'b0;
        #1;
        chk({name, "_ready"}, {63'b0, in_ready_o}, 64'd1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        chk({name, "_early"}, {63'b0, out_valid_o}, 64'd0);
        @(posedge clk); #1;
        chk({name, "_valid"}, {63'b0, out_valid_o}, 64'd1);
        chk({name, "_cnt"}, {57'b0, out_cnt_o}, 64'(ecnt));
        chk({name, "_zero"}, {63'b0, out_zero_o}, {63'b0, ezero});
        chk({name, "_tag"}, {58'b0, out_tag_o}, {58'b0, tag});
    endtask

    task automatic rand_operand();
        logic [63:0] d;
        d = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: d = '0;
            1: d = 64'd1 << $urandom_range(0, 63);
            2: d = d >> $urandom_range(0, 63);
            default: ;
        endcase
        in_data_i = d;
        in_op_i = 2'($urandom_range(0, 3));
        in_word_i = 1'($urandom_range(0, 1));
    endtask

    int          accepts;
    logic [6:0]  hold_cnt;
    logic [5:0]  hold_tag;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'b0, out_valid_o}, 64'd0);
        chk("rst_cnt", {57'b0, out_cnt_o}, 64'd0);
        chk("rst_tag", {58'b0, out_tag_o}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", {63'b0, in_ready_o}, 64'd1);

        // Directed literal cases
        direct("clz_w",      64'h0000_0000_0001_0000, 2'd0, 1'b1, 6'd1, 15, 1'b0);
        direct("ctz_w",      64'h0000_0000_0001_0000, 2'd1, 1'b1, 6'd2, 16, 1'b0);
        direct("cpop_w",     64'h0000_0000_F0F0_0001, 2'd2, 1'b1, 6'd3, 9,  1'b0);
        direct("clz_zero",   64'h0,                   2'd0, 1'b0, 6'd4, 64, 1'b1);
        direct("clz_zero_w", 64'h0,                   2'd0, 1'b1, 6'd5, 32, 1'b1);
        direct("cpop_zero",  64'h0,                   2'd2, 1'b0, 6'd6, 0,  1'b1);
        direct("ctz_msb",    64'h8000_0000_0000_0000, 2'd1, 1'b0, 6'd7, 63, 1'b0);
        direct("clz_wmask",  64'hFFFF_FFFF_0000_0001, 2'd0, 1'b1, 6'd8, 31, 1'b0);
        direct("ctz_wmask",  64'hFFFF_FFFF_0000_0000, 2'd1, 1'b1, 6'd9, 32, 1'b1);
        direct("cpop_full",  64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 1'b0, 6'd10, 64, 1'b0);
        direct("rsv_op",     64'h5,                   2'd3, 1'b0, 6'd11, 0, 1'b0);

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            in_valid_i = 1'b1; rand_operand(); in_tag_i = 6'(12 + i); out_ready_i = 1'b1;
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Output stall: two accepts fill the pipe, then input backs up
        accepts = 0;
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; rand_operand(); in_tag_i = 6'(20 + i);
            #1;
            if (in_ready_o) accepts++;
            hold_cnt = out_cnt_o; hold_tag = out_tag_o;
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        chk("stall_accepts", 64'(accepts), 64'd2);
        chk("stall_hold_valid", {63'b0, out_valid_o}, 64'd1);
        chk("stall_hold_cnt", {57'b0, out_cnt_o}, {57'b0, hold_cnt});
        chk("stall_hold_tag", {58'b0, out_tag_o}, 64'd20);
        chk("stall_hold_tag2", {58'b0, out_tag_o}, {58'b0, hold_tag});
        out_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_drained", 64'(q.size()), 64'd0);

        // Randomised traffic with backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid_i = ($urandom_range(0, 9) < 7);
            rand_operand();
            in_tag_i = 6'($urandom_range(0, 47));
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 24) == 0);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("random_drained", 64'(q.size()), 64'd0);

        // Flush with two ops in flight
        in_valid_i = 1'b1; out_ready_i = 1'b0; in_data_i = 64'h1; in_op_i = 2'd0; in_word_i = 1'b0;
        in_tag_i = 6'h30;
        @(posedge clk); #1;
        in_tag_i = 6'h31;
        @(posedge clk); #1;
        in_valid_i = 1'b0; flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; out_ready_i = 1'b1;
        chk("flush_valid", {63'b0, out_valid_o}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_quiet", {63'b0, out_valid_o}, 64'd0);
        end
        direct("post_flush", 64'h0000_0000_0000_0100, 2'd1, 1'b0, 6'd40, 8, 1'b0);
        chk("flushed_tags", 64'(flushed_seen), 64'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid_i = 1'b1; in_data_i = 64'hFF00; in_op_i = 2'd2; in_word_i = 1'b0;
            in_tag_i = 6'(41 + i);
        end
        @(posedge clk); #3;
        rst_n = 1'b0; in_valid_i = 1'b0;
        #1;
        chk("arst_valid", {63'b0, out_valid_o}, 64'd0);
        chk("arst_cnt", {57'b0, out_cnt_o}, 64'd0);
        chk("arst_zero", {63'b0, out_zero_o}, 64'd0);
        chk("arst_tag", {58'b0, out_tag_o}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("arst_ready", {63'b0, in_ready_o}, 64'd1);
        direct("post_reset_clz1", 64'h1, 2'd0, 1'b1, 6'd5, 31, 1'b0);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
